// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Divisors below MIN_DIV cannot form a low/high period and are rejected.
package clk_div_pkg;

  localparam int unsigned MIN_DIV = 2;

  function automatic int unsigned half_up(input int unsigned n);
    return (n + 1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter with registered clk_div/tick decode.
// Flops load from next-state decode so outputs match the current count.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] active,
  input  logic [WIDTH-1:0] div_next,
  output logic             wrap,
  output logic             clk_div,
  output logic             tick
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;

  assign wrap = en && (cnt == active - 1'b1);

  always_comb begin
    cnt_nxt = cnt;
    if (clr || wrap) begin
      cnt_nxt = '0;
    end else if (en) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      clk_div <= 1'b0;
      tick    <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (clr) begin
        clk_div <= 1'b0;
        tick    <= 1'b0;
      end else if (en) begin
        clk_div <= 32'(cnt_nxt) >= half_up(32'(div_next));
        tick    <= cnt_nxt == div_next - 1'b1;
      end else begin
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clock_div_prog.sv
// Runtime-programmable integer clock divider producing enables.
// New divisors wait in a shadow register until a period boundary.
module clock_div_prog
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 7
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_in,
  output logic             clk_div,
  output logic             tick,
  output logic             load_err,
  output logic             pending,
  output logic [WIDTH-1:0] cur_div
);

  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] active_nxt;
  logic [WIDTH-1:0] shadow_nxt;
  logic             pending_nxt;
  logic             wrap;
  logic             valid;
  logic             boundary;

  assign valid    = div_load && (32'(div_in) >= MIN_DIV);
  assign boundary = sync_clr || wrap;
  assign cur_div  = active;

  // A valid load at a boundary bypasses the shadow and applies at once.
  always_comb begin
    active_nxt  = active;
    shadow_nxt  = shadow;
    pending_nxt = pending;
    if (boundary) begin
      if (valid) begin
        active_nxt  = div_in;
        shadow_nxt  = div_in;
        pending_nxt = 1'b0;
      end else if (pending) begin
        active_nxt  = shadow;
        pending_nxt = 1'b0;
      end
    end else if (valid) begin
      shadow_nxt  = div_in;
      pending_nxt = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      active   <= WIDTH'(DEFAULT_DIV);
      shadow   <= WIDTH'(DEFAULT_DIV);
      pending  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      active   <= active_nxt;
      shadow   <= shadow_nxt;
      pending  <= pending_nxt;
      load_err <= div_load && !valid;
    end
  end

  clk_div_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clock    (clock),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (sync_clr),
    .active   (active),
    .div_next (active_nxt),
    .wrap     (wrap),
    .clk_div  (clk_div),
    .tick     (tick)
  );

endmodule

// File: tb/tb_clock_div_prog.sv
// Directed bench for clock_div_prog with a cycle-level reference model.
// The model tracks count/divisor state and derives outputs arithmetically.
module tb_clock_div_prog;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       sync_clr = 1'b0;
  logic       div_load = 1'b0;
  logic [7:0] div_in = '0;
  logic       clk_div;
  logic       tick;
  logic       load_err;
  logic       pending;
  logic [7:0] cur_div;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int m_cnt;
  int m_act;
  int m_sh;
  bit m_pend;
  bit m_err;
  bit m_en_prev;

  always #5 clock = ~clock;

  clock_div_prog #(
    .WIDTH(8),
    .DEFAULT_DIV(7)
  ) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .en       (en),
    .sync_clr (sync_clr),
    .div_load (div_load),
    .div_in   (div_in),
    .clk_div  (clk_div),
    .tick     (tick),
    .load_err (load_err),
    .pending  (pending),
    .cur_div  (cur_div)
  );

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_act = 7;
    m_sh = 7;
    m_pend = 0;
    m_err = 0;
    m_en_prev = 0;
  endtask

  task automatic compare();
    int exp_clk;
    int exp_tick;
    exp_clk = (m_cnt >= (m_act + 1) / 2) ? 1 : 0;
    exp_tick = (m_en_prev && m_cnt == m_act - 1) ? 1 : 0;
    chk("m_clk_div", 32'(clk_div), 32'(exp_clk));
    chk("m_tick", 32'(tick), 32'(exp_tick));
    chk("m_load_err", 32'(load_err), 32'(m_err));
    chk("m_pending", 32'(pending), 32'(m_pend));
    chk("m_cur_div", 32'(cur_div), 32'(m_act));
  endtask

  task automatic step();
    bit ok;
    bit wr;
    bit bnd;
    ok = div_load && div_in >= 2;
    wr = en && m_cnt == m_act - 1;
    bnd = sync_clr || wr;
    m_err = div_load && div_in < 2;
    if (bnd) begin
      m_cnt = 0;
      if (ok) begin
        m_act = div_in;
        m_sh = div_in;
        m_pend = 0;
      end else if (m_pend) begin
        m_act = m_sh;
        m_pend = 0;
      end
    end else begin
      if (en) m_cnt = m_cnt + 1;
      if (ok) begin
        m_sh = div_in;
        m_pend = 1;
      end
    end
    m_en_prev = en;
    @(posedge clock);
    #1;
    cyc++;
    compare();
  endtask

  task automatic run_to(input int k);
    for (int i = 0; i < 300 && m_cnt != k; i++) step();
    if (m_cnt != k) chk("run_to_timeout", 32'(m_cnt), 32'(k));
  endtask

  task automatic ticks_after(output int n);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      n++;
      if (tick) break;
    end
  endtask

  task automatic clr_load(input logic [7:0] d);
    sync_clr = 1;
    div_load = 1;
    div_in = d;
    step();
    sync_clr = 0;
    div_load = 0;
  endtask

  initial begin
    int tq[$];
    logic [6:0] p7;
    logic [3:0] p4;
    int n;

    repeat (2) @(posedge clock);
    #1;
    rst_n = 1;
    model_reset();
    compare();
    chk("rst_clk_div", 32'(clk_div), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_cur_div", 32'(cur_div), 7);

    // default N=7 from reset
    en = 1;
    p7[6] = clk_div;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i < 7) p7[6-i] = clk_div;
      if (tick) tq.push_back(cyc);
    end
    chk("n7_clk_pat", 32'(p7), 32'(7'b0000111));
    chk("n7_tick_cnt", 32'(tq.size()), 3);
    if (tq.size() == 3) begin
      chk("n7_tick0", 32'(tq[0]), 6);
      chk("n7_tick1", 32'(tq[1]), 13);
      chk("n7_tick2", 32'(tq[2]), 20);
    end

    // load 4 mid-period
    run_to(2);
    div_load = 1;
    div_in = 4;
    step();
    div_load = 0;
    chk("ld4_pend", 32'(pending), 1);
    run_to(6);
    chk("ld4_pend_wrap", 32'(pending), 1);
    chk("ld4_old_div", 32'(cur_div), 7);
    step();
    chk("ld4_cur", 32'(cur_div), 4);
    chk("ld4_pend_clr", 32'(pending), 0);
    p4[3] = clk_div;
    for (int i = 2; i >= 0; i--) begin
      step();
      p4[i] = clk_div;
    end
    chk("ld4_clk_pat", 32'(p4), 32'(4'b0011));
    chk("ld4_tick", 32'(tick), 1);

    // rejected loads
    clr_load(8'd7);
    chk("clr7_cur", 32'(cur_div), 7);
    div_load = 1;
    div_in = 1;
    step();
    chk("err1", 32'(load_err), 1);
    div_in = 0;
    step();
    chk("err0", 32'(load_err), 1);
    div_load = 0;
    step();
    chk("err_clr", 32'(load_err), 0);
    chk("err_cur", 32'(cur_div), 7);
    chk("err_pend", 32'(pending), 0);
    ticks_after(n);
    chk("err_first", 32'(n), 3);
    ticks_after(n);
    chk("err_period", 32'(n), 7);

    // load at the wrap cycle
    run_to(6);
    div_load = 1;
    div_in = 5;
    step();
    div_load = 0;
    chk("wrap5_cur", 32'(cur_div), 5);
    chk("wrap5_pend", 32'(pending), 0);
    ticks_after(n);
    chk("wrap5_first", 32'(n), 4);
    ticks_after(n);
    chk("wrap5_period", 32'(n), 5);

    // enable pause
    clr_load(8'd7);
    run_to(3);
    en = 0;
    repeat (10) begin
      step();
      chk("hold_clk", 32'(clk_div), 0);
      chk("hold_tick", 32'(tick), 0);
    end
    en = 1;
    ticks_after(n);
    chk("resume_tick", 32'(n), 3);

    // async reset with pending load
    run_to(2);
    div_load = 1;
    div_in = 9;
    step();
    div_load = 0;
    run_to(5);
    chk("pre_rst_pend", 32'(pending), 1);
    chk("pre_rst_clk", 32'(clk_div), 1);
    rst_n = 0;
    #1;
    model_reset();
    chk("arst_clk", 32'(clk_div), 0);
    chk("arst_tick", 32'(tick), 0);
    chk("arst_cur", 32'(cur_div), 7);
    chk("arst_pend", 32'(pending), 0);
    @(posedge clock);
    #1;
    rst_n = 1;
    repeat (4) step();
    clr_load(8'd3);
    chk("clr3_cur", 32'(cur_div), 3);
    chk("clr3_clk", 32'(clk_div), 0);
    ticks_after(n);
    chk("clr3_first", 32'(n), 2);
    ticks_after(n);
    chk("clr3_period", 32'(n), 3);

    // N=2
    clr_load(8'd2);
    p4[3] = clk_div;
    for (int i = 2; i >= 0; i--) begin
      step();
      p4[i] = clk_div;
    end
    chk("n2_clk_pat", 32'(p4), 32'(4'b0101));

    // maximum divisor
    clr_load(8'd255);
    ticks_after(n);
    chk("n255_first", 32'(n), 254);
    ticks_after(n);
    chk("n255_period", 32'(n), 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_div_prog.md
# clock_div_prog

Runtime-programmable integer clock divider: the parametrised successor to the fixed divide-by-7 ring divider. It produces a near-50% duty divided clock and a one-cycle period tick from a single system clock, with a divisor that can be changed without glitches at period boundaries. It sits beside the counter and display blocks and feeds their enables; its outputs are enables, not clocks for other flops.

## Interface
- `WIDTH`, default 8: divisor and counter width. Maximum divisor is 2^WIDTH−1.
- `DEFAULT_DIV`, default 7: divisor after reset. Must satisfy 2 ≤ DEFAULT_DIV ≤ 2^WIDTH−1.
- `clock`  in  1: the single clock. All logic is rising-edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: count enable. When low, the counter and outputs freeze.
- `sync_clr`  in  1: synchronous restart of the period.
- `div_load`  in  1: one-cycle strobe that loads `div_in`.
- `div_in`  in  WIDTH: requested divisor N.
- `clk_div`  out  1: divided square output, driven directly from a flop.
- `tick`  out  1: one-cycle pulse on the last cycle of each period, driven directly from a flop.
- `load_err`  out  1: one-cycle pulse when a load is rejected.
- `pending`  out  1: a loaded divisor is waiting for the next period boundary.
- `cur_div`  out  WIDTH: divisor currently in force.

## Operation
- State: `cnt` ranges over 0..N−1. `active` holds the divisor in force. `shadow` holds the next divisor. `pending` is a flag.
- Reset values: `cnt`=0; `active`=`shadow`=DEFAULT_DIV; `pending`=0; `clk_div`=0; `tick`=0; `load_err`=0.
- Decode, for the cycle in which `cnt`=k:
  - `clk_div`=1 iff k ≥ ceil(N/2). The output is low for ceil(N/2) cycles and high for floor(N/2) cycles.
  - `tick`=1 iff k = N−1 and `en`=1.
- Wrap: when `en`=1 and `cnt`=N−1:
  - `cnt`←0.
  - If `pending`=1, then `active`←`shadow` and `pending`←0.
- Load with `div_in` ≥ 2: `shadow`←`div_in` and `pending`←1. The last load before a wrap wins.
- Load with `div_in` < 2: `load_err` pulses for one cycle. `shadow`, `pending` and `active` are unchanged.
- Load in the wrap cycle: the loaded value applies at that same wrap (bypass), so the next period uses it and `pending` stays 0.
- `sync_clr`=1:
  - `cnt`←0.
  - If pending, `active`←`shadow` and `pending`←0.
  - `clk_div` and `tick` go low on the next cycle.
  - A valid load in the same cycle applies immediately.
  - `sync_clr` overrides `en`.
- `en`=0: `cnt`, `clk_div` and `cur_div` hold, and `tick` is 0. Loads are still accepted into `shadow`.
- Reset asserted mid-period: all state returns to reset values asynchronously. After release, counting restarts at `cnt`=0 with DEFAULT_DIV.

## Timing
- Outputs are registered. The value shown for the cycle with `cnt`=k is visible in that same cycle, because the flop is loaded from next-state decode.
- Period is exactly N enabled cycles. There is no dead cycle at a wrap, and none at a divisor change.
- `load_err` is visible one cycle after the `div_load` edge.
- `pending` rises one cycle after a valid load. `cur_div` updates in the first cycle of the new period.
- N=2: `clk_div` toggles every cycle, and `tick` fires on every odd-count cycle.
- Maximum N: `cnt` never exceeds N−1, and there is no overflow at 2^WIDTH−1.

## Structure
- Shared package `clk_div_pkg`:
  - constant `MIN_DIV`=2;
  - function `half_up(N)` = (N+1)>>1, used for the duty threshold.
- Sub-module `clk_div_core`: contains `cnt`, the wrap detect and the registered `clk_div`/`tick` decode for a given `active`. The top level owns `shadow`, `pending`, load validation and `sync_clr` priority.

## Test plan
- Reset release, `en`=1, default N=7:
  - `tick` on cycles 6, 13, 20.
  - `clk_div` low for 4 cycles, then high for 3, repeating.
- Load 4 at `cnt`=2 of a 7-period:
  - `pending`=1 until the wrap at `cnt`=6.
  - The next period is 4 cycles: `clk_div` 2 low, 2 high.
  - `cur_div`=4.
- Load 1, then load 0:
  - `load_err` pulses once for each load.
  - `cur_div` stays 7.
  - `pending`=0.
  - The period stays 7.
- Load 5 exactly at the wrap cycle: the very next period is 5 cycles long, and `pending` never rises.
- `en` low for 10 cycles at `cnt`=3:
  - `clk_div` holds and `tick` stays 0.
  - After resume, the next `tick` comes 3 enabled cycles later.
- Reset and clear mid-period:
  - `rst_n` pulsed low at `cnt`=5 with N=9 pending: outputs are 0 immediately and `cur_div` returns to 7.
  - `sync_clr` with a load of 3: `cnt`=0 and the next period is 3 cycles.
